// File: rtl/pc_seq_unit_if.sv
// pc_seq_unit_if: control/fetch-side bundle of the program-counter sequencer.
//   master : control FSM side (drives stall, state, step and redirect strobes)
//   slave  : the sequencer (drives pc_out, pc_plus4 and status pulses)
// Optional macro PC_HALT_EN adds the halted status signal.
interface pc_seq_unit_if #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned STATE_W = 3
);
    logic               stall;
    logic [STATE_W-1:0] state;
    logic               pc_step;
    logic               redirect_valid;
    logic               redirect_delayed;
    logic [ADDR_W-1:0]  redirect_target;
    logic [ADDR_W-1:0]  pc_out;
    logic [ADDR_W-1:0]  pc_plus4;
    logic               branch_pending;
    logic               redirect_dropped;
    logic               addr_misaligned;
`ifdef PC_HALT_EN
    logic               halted;
`endif

    modport master (
        output stall, state, pc_step, redirect_valid, redirect_delayed, redirect_target,
        input  pc_out, pc_plus4, branch_pending, redirect_dropped, addr_misaligned
`ifdef PC_HALT_EN
        , input halted
`endif
    );

    modport slave (
        input  stall, state, pc_step, redirect_valid, redirect_delayed, redirect_target,
        output pc_out, pc_plus4, branch_pending, redirect_dropped, addr_misaligned
`ifdef PC_HALT_EN
        , output halted
`endif
    );
endinterface

// File: rtl/pc_seq_unit.sv
// pc_seq_unit: program-counter sequencer for the multicycle MIPS core.
// Holds the fetch address, steps it by 4, applies immediate redirects at once
// and delayed (branch) redirects after DELAY_SLOTS further fetches.
// Ports:
//   clk    - clock, rising edge
//   reset  - synchronous active-high reset
//   bus    - pc_seq_unit_if.slave: stall/state/pc_step/redirect_* in,
//            pc_out/pc_plus4/branch_pending/redirect_dropped/addr_misaligned out
// Optional feature macro: PC_HALT_EN (adds bus.halted; a zero target halts).
module pc_seq_unit #(
    parameter int unsigned       ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(32'hBFC00000),
    parameter int unsigned       DELAY_SLOTS  = 1,
    parameter int unsigned       STATE_W      = 3
) (
    input  logic         clk,
    input  logic         reset,
    pc_seq_unit_if.slave bus
);
    localparam int unsigned        CNT_W       = 3;
    localparam logic [CNT_W-1:0]   SLOTS_FULL  = CNT_W'(DELAY_SLOTS);
    localparam logic [CNT_W-1:0]   SLOTS_STEP  = CNT_W'(DELAY_SLOTS - 1);
    localparam bit                 NO_DELAY    = (DELAY_SLOTS == 0);
    localparam logic [STATE_W-1:0] FETCH_INSTR = '0;

    typedef enum logic {BR_IDLE, BR_PENDING} br_state_t;

    br_state_t         br_q, br_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              dropped_q, dropped_d;
    logic              misal_q, misal_d;
    logic              halted_q, halted_d;

    logic              active;
    logic              step_ok;
    logic              imm_req;
    logic              dly_req;
    logic [ADDR_W-1:0] tgt_aligned;
    logic [ADDR_W-1:0] pc_inc;

    assign pc_inc      = pc_q + ADDR_W'(4);
    assign tgt_aligned = {bus.redirect_target[ADDR_W-1:2], 2'b00};
    assign step_ok     = bus.pc_step && (bus.state == FETCH_INSTR);
    // With no delay slots a branch-type redirect behaves as an immediate one.
    assign imm_req     = bus.redirect_valid && (!bus.redirect_delayed || NO_DELAY);
    assign dly_req     = bus.redirect_valid && bus.redirect_delayed && !NO_DELAY;

`ifdef PC_HALT_EN
    assign active = !bus.stall && !halted_q;
`else
    assign active = !bus.stall;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            br_q      <= BR_IDLE;
            pc_q      <= RESET_VECTOR;
            tgt_q     <= '0;
            cnt_q     <= '0;
            dropped_q <= 1'b0;
            misal_q   <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            br_q      <= br_d;
            pc_q      <= pc_d;
            tgt_q     <= tgt_d;
            cnt_q     <= cnt_d;
            dropped_q <= dropped_d;
            misal_q   <= misal_d;
            halted_q  <= halted_d;
        end
    end

    // Next-state: redirect/step priority resolution.
    always_comb begin
        br_d      = br_q;
        pc_d      = pc_q;
        tgt_d     = tgt_q;
        cnt_d     = cnt_q;
        dropped_d = 1'b0;
        misal_d   = 1'b0;
        halted_d  = halted_q;

        if (active) begin
            if (imm_req) begin
                pc_d    = tgt_aligned;
                br_d    = BR_IDLE;
                tgt_d   = '0;
                cnt_d   = '0;
                misal_d = |bus.redirect_target[1:0];
`ifdef PC_HALT_EN
                if (tgt_aligned == '0) halted_d = 1'b1;
`endif
            end else if (dly_req && (br_q == BR_IDLE)) begin
                tgt_d   = tgt_aligned;
                br_d    = BR_PENDING;
                misal_d = |bus.redirect_target[1:0];
                if (step_ok) begin
                    // The step consumes the first slot; a zero count commits on the next step.
                    pc_d  = pc_inc;
                    cnt_d = SLOTS_STEP;
                end else begin
                    cnt_d = SLOTS_FULL;
                end
            end else begin
                if (dly_req) dropped_d = 1'b1;
                if (step_ok) begin
                    if (br_q == BR_PENDING) begin
                        if (cnt_q <= CNT_W'(1)) begin
                            pc_d  = tgt_q;
                            br_d  = BR_IDLE;
                            cnt_d = '0;
`ifdef PC_HALT_EN
                            if (tgt_q == '0) halted_d = 1'b1;
`endif
                        end else begin
                            pc_d  = pc_inc;
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end else begin
                        pc_d = pc_inc;
                    end
                end
            end
        end
    end

    assign bus.pc_out           = pc_q;
    assign bus.pc_plus4         = pc_inc;
    assign bus.branch_pending   = (br_q == BR_PENDING);
    assign bus.redirect_dropped = dropped_q;
    assign bus.addr_misaligned  = misal_q;
`ifdef PC_HALT_EN
    assign bus.halted           = halted_q;
`endif

endmodule

// File: tb/tb_pc_seq_unit.sv
// tb_pc_seq_unit: directed bench for pc_seq_unit with DELAY_SLOTS = 1, 3 and 0.
module tb_pc_seq_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [2:0]  state;
    logic        pc_step;
    logic        rv;
    logic        rd;
    logic [31:0] rt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_seq_unit_if #(.ADDR_W(32), .STATE_W(3)) bus1 ();
    pc_seq_unit_if #(.ADDR_W(32), .STATE_W(3)) bus3 ();
    pc_seq_unit_if #(.ADDR_W(32), .STATE_W(3)) bus0 ();

    assign bus1.stall = stall;  assign bus3.stall = stall;  assign bus0.stall = stall;
    assign bus1.state = state;  assign bus3.state = state;  assign bus0.state = state;
    assign bus1.pc_step = pc_step;  assign bus3.pc_step = pc_step;  assign bus0.pc_step = pc_step;
    assign bus1.redirect_valid = rv;  assign bus3.redirect_valid = rv;  assign bus0.redirect_valid = rv;
    assign bus1.redirect_delayed = rd;  assign bus3.redirect_delayed = rd;  assign bus0.redirect_delayed = rd;
    assign bus1.redirect_target = rt;  assign bus3.redirect_target = rt;  assign bus0.redirect_target = rt;

    pc_seq_unit #(.ADDR_W(32), .RESET_VECTOR(32'hBFC00000), .DELAY_SLOTS(1), .STATE_W(3))
        dut1 (.clk(clk), .reset(reset), .bus(bus1));
    pc_seq_unit #(.ADDR_W(32), .RESET_VECTOR(32'hBFC00000), .DELAY_SLOTS(3), .STATE_W(3))
        dut3 (.clk(clk), .reset(reset), .bus(bus3));
    pc_seq_unit #(.ADDR_W(32), .RESET_VECTOR(32'hBFC00000), .DELAY_SLOTS(0), .STATE_W(3))
        dut0 (.clk(clk), .reset(reset), .bus(bus0));

    typedef struct {
        logic        rst;
        logic        stl;
        logic [2:0]  st;
        logic        step;
        logic        rv;
        logic        rd;
        logic [31:0] rt;
        logic [31:0] pc;
        logic        bp;
        logic        drop;
        logic        mis;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Present inputs on the falling edge, sample 1 ns after the rising edge.
    task automatic drive(input logic r, input logic s, input logic [2:0] st, input logic step,
                         input logic v, input logic d, input logic [31:0] t);
        @(negedge clk);
        reset = r; stall = s; state = st; pc_step = step; rv = v; rd = d; rt = t;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic s, input logic [2:0] st, input logic step,
                       input logic v, input logic d, input logic [31:0] t,
                       input logic [31:0] pc, input logic bp, input logic drop, input logic mis);
        vec_t e;
        e.rst = r; e.stl = s; e.st = st; e.step = step; e.rv = v; e.rd = d; e.rt = t;
        e.pc = pc; e.bp = bp; e.drop = drop; e.mis = mis;
        vq.push_back(e);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; state = 3'd0; pc_step = 1'b0; rv = 1'b0; rd = 1'b0; rt = '0;

        //   rst stl st  stp rv rd target          pc               bp drop mis
        add(1, 0, 0, 0, 0, 0, 32'h0,          32'hBFC00000, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 32'h0,          32'hBFC00004, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 32'h0,          32'hBFC00008, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 32'h0,          32'hBFC0000C, 0, 0, 0);
        add(0, 0, 2, 1, 0, 0, 32'h0,          32'hBFC0000C, 0, 0, 0);
        add(0, 0, 2, 1, 0, 0, 32'h0,          32'hBFC0000C, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 32'h100,        32'h100,      0, 0, 0);
        add(0, 0, 0, 0, 1, 1, 32'h400,        32'h100,      1, 0, 0);
        add(0, 0, 0, 1, 0, 0, 32'h0,          32'h400,      0, 0, 0);
        add(0, 0, 0, 1, 1, 1, 32'h800,        32'h404,      1, 0, 0);
        add(0, 0, 0, 1, 0, 0, 32'h0,          32'h800,      0, 0, 0);
        add(0, 0, 0, 0, 1, 1, 32'h900,        32'h800,      1, 0, 0);
        add(0, 0, 0, 0, 1, 1, 32'hA00,        32'h800,      1, 1, 0);
        add(0, 0, 0, 1, 0, 0, 32'h0,          32'h900,      0, 0, 0);
        add(0, 0, 0, 0, 1, 1, 32'hC00,        32'h900,      1, 0, 0);
        add(0, 0, 0, 1, 1, 0, 32'h40,         32'h40,       0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 32'h0,          32'h44,       0, 0, 0);
        add(0, 0, 0, 0, 1, 1, 32'h500,        32'h44,       1, 0, 0);
        add(0, 1, 0, 1, 1, 0, 32'h700,        32'h44,       1, 0, 0);
        add(0, 1, 0, 1, 1, 1, 32'h703,        32'h44,       1, 0, 0);
        add(0, 1, 0, 1, 1, 0, 32'h700,        32'h44,       1, 0, 0);
        add(0, 1, 0, 1, 1, 1, 32'h700,        32'h44,       1, 0, 0);
        add(0, 0, 0, 1, 0, 0, 32'h0,          32'h500,      0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 32'h103,        32'h100,      0, 0, 1);
        add(0, 0, 0, 1, 0, 0, 32'h0,          32'h104,      0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 32'hFFFFFFFC,   32'hFFFFFFFC, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 32'h0,          32'h0,        0, 0, 0);
        add(0, 0, 0, 1, 1, 1, 32'h32,         32'h4,        1, 0, 1);
        add(0, 0, 0, 1, 1, 1, 32'h600,        32'h30,       0, 1, 0);
        add(0, 0, 0, 0, 1, 1, 32'h700,        32'h30,       1, 0, 0);
        add(1, 1, 0, 1, 1, 0, 32'h800,        32'hBFC00000, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 32'h0,          32'hBFC00004, 0, 0, 0);

        foreach (vq[i]) begin
            drive(vq[i].rst, vq[i].stl, vq[i].st, vq[i].step, vq[i].rv, vq[i].rd, vq[i].rt);
            check($sformatf("v%0d_pc", i), bus1.pc_out, vq[i].pc);
            check($sformatf("v%0d_pc_plus4", i), bus1.pc_plus4, vq[i].pc + 32'd4);
            check($sformatf("v%0d_branch_pending", i), 32'(bus1.branch_pending), 32'(vq[i].bp));
            check($sformatf("v%0d_redirect_dropped", i), 32'(bus1.redirect_dropped), 32'(vq[i].drop));
            check($sformatf("v%0d_addr_misaligned", i), 32'(bus1.addr_misaligned), 32'(vq[i].mis));
        end

        // Three delay slots: redirect without a step, then with a step.
        drive(1, 0, 0, 0, 0, 0, 32'h0);
        check("ds3_reset_pc", bus3.pc_out, 32'hBFC00000);
        drive(0, 0, 0, 0, 1, 0, 32'h200);
        check("ds3_imm_pc", bus3.pc_out, 32'h200);
        drive(0, 0, 0, 0, 1, 1, 32'h800);
        check("ds3_accept_pc", bus3.pc_out, 32'h200);
        check("ds3_accept_bp", 32'(bus3.branch_pending), 32'd1);
        drive(0, 0, 0, 1, 0, 0, 32'h0);
        check("ds3_step1_pc", bus3.pc_out, 32'h204);
        drive(0, 0, 0, 1, 0, 0, 32'h0);
        check("ds3_step2_pc", bus3.pc_out, 32'h208);
        check("ds3_step2_bp", 32'(bus3.branch_pending), 32'd1);
        drive(0, 0, 0, 1, 0, 0, 32'h0);
        check("ds3_step3_pc", bus3.pc_out, 32'h800);
        check("ds3_step3_bp", 32'(bus3.branch_pending), 32'd0);
        drive(0, 0, 0, 1, 1, 1, 32'h900);
        check("ds3_acc_step_pc", bus3.pc_out, 32'h804);
        drive(0, 0, 0, 1, 0, 0, 32'h0);
        check("ds3_acc_step1_pc", bus3.pc_out, 32'h808);
        drive(0, 0, 0, 1, 0, 0, 32'h0);
        check("ds3_acc_step2_pc", bus3.pc_out, 32'h900);
        check("ds3_acc_step2_bp", 32'(bus3.branch_pending), 32'd0);

        // Zero delay slots: a delayed redirect applies immediately.
        drive(1, 0, 0, 0, 0, 0, 32'h0);
        drive(0, 0, 0, 1, 1, 1, 32'h301);
        check("ds0_pc", bus0.pc_out, 32'h300);
        check("ds0_bp", 32'(bus0.branch_pending), 32'd0);
        check("ds0_mis", 32'(bus0.addr_misaligned), 32'd1);
        drive(0, 0, 0, 0, 1, 1, 32'h500);
        check("ds0_no_drop", 32'(bus0.redirect_dropped), 32'd0);
        check("ds0_pc2", bus0.pc_out, 32'h500);

`ifdef PC_HALT_EN
        drive(1, 0, 0, 0, 0, 0, 32'h0);
        check("halt_reset", 32'(bus1.halted), 32'd0);
        drive(0, 0, 0, 1, 1, 0, 32'h0);
        check("halt_set", 32'(bus1.halted), 32'd1);
        check("halt_pc", bus1.pc_out, 32'h0);
        drive(0, 0, 0, 1, 0, 0, 32'h0);
        check("halt_step_ignored", bus1.pc_out, 32'h0);
        drive(0, 0, 0, 0, 1, 1, 32'h400);
        check("halt_redirect_ignored", 32'(bus1.branch_pending), 32'd0);
        drive(0, 0, 0, 0, 1, 0, 32'h403);
        check("halt_no_pulse", 32'(bus1.addr_misaligned), 32'd0);
        check("halt_imm_ignored", bus1.pc_out, 32'h0);
        drive(1, 0, 0, 0, 0, 0, 32'h0);
        check("halt_cleared", 32'(bus1.halted), 32'd0);
        check("halt_reset_pc", bus1.pc_out, 32'hBFC00000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
